// File: rtl/video_timing_ctl.sv
// video_timing_ctl
//   Programmable raster sequencer for the mixer's sync inputs. Pixel and line
//   counters run against an active timing set. The outputs (position, syncs,
//   active video and frame start) are registered and come out one pixel per clock.
//   Timing updates are validated and then held in a staging set. The staging set
//   is copied into the active set as a whole, so a frame never mixes old and new
//   timing.
//
//   Build option VIDEO_TIMING_SHADOW_EN:
//     defined   - an accepted update is committed at frame end; the current
//                 frame finishes with the old timing.
//     undefined - an accepted update is committed on the next cycle and the
//                 counters restart at (0,0), which truncates the current frame.
//     In IDLE an accepted update goes straight into the active set.
//
//   Ports
//     clk, rst             clock; synchronous active-low reset
//     enable_i             run the raster; low aborts and holds (0,0)
//     h_*_i, v_*_i         candidate timing (12 bit each)
//     timing_update_i      single-cycle pulse that captures the candidate timing.
//                          There is no ready: every pulse is evaluated on the
//                          edge that samples it.
//     h_pos_o, v_pos_o     pixel / line position
//     h_sync_o, v_sync_o   syncs, active high
//     pixel_en_o           active video
//     frame_start_o        high together with position (0,0)
//     timing_error_o       sticky; set by a rejected update, cleared by an accepted one
//     dbg_state_o          FSM state (0 = IDLE, 1 = RUN)
module video_timing_ctl #(
  parameter logic [11:0] H_ACTIVE_DEF     = 12'd720,
  parameter logic [11:0] H_SYNC_START_DEF = 12'd732,
  parameter logic [11:0] H_SYNC_END_DEF   = 12'd796,
  parameter logic [11:0] H_TOTAL_DEF      = 12'd863,
  parameter logic [11:0] V_ACTIVE_DEF     = 12'd576,
  parameter logic [11:0] V_SYNC_START_DEF = 12'd581,
  parameter logic [11:0] V_SYNC_END_DEF   = 12'd586,
  parameter logic [11:0] V_TOTAL_DEF      = 12'd624
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable_i,
  input  logic [11:0] h_active_i,
  input  logic [11:0] h_sync_start_i,
  input  logic [11:0] h_sync_end_i,
  input  logic [11:0] h_total_i,
  input  logic [11:0] v_active_i,
  input  logic [11:0] v_sync_start_i,
  input  logic [11:0] v_sync_end_i,
  input  logic [11:0] v_total_i,
  input  logic        timing_update_i,
  output logic [11:0] h_pos_o,
  output logic [11:0] v_pos_o,
  output logic        h_sync_o,
  output logic        v_sync_o,
  output logic        pixel_en_o,
  output logic        frame_start_o,
  output logic        timing_error_o,
  output logic        dbg_state_o
);

  typedef enum logic {ST_IDLE = 1'b0, ST_RUN = 1'b1} state_t;

  typedef struct packed {
    logic [11:0] h_active;
    logic [11:0] h_sync_start;
    logic [11:0] h_sync_end;
    logic [11:0] h_total;
    logic [11:0] v_active;
    logic [11:0] v_sync_start;
    logic [11:0] v_sync_end;
    logic [11:0] v_total;
  } timing_t;

  localparam timing_t TIMING_DEF = {H_ACTIVE_DEF, H_SYNC_START_DEF, H_SYNC_END_DEF, H_TOTAL_DEF,
                                    V_ACTIVE_DEF, V_SYNC_START_DEF, V_SYNC_END_DEF, V_TOTAL_DEF};

  function automatic logic timing_ok(input timing_t t);
    return (t.h_active != 12'd0) && (t.h_active <= t.h_sync_start) &&
           (t.h_sync_start < t.h_sync_end) && (t.h_sync_end <= t.h_total) &&
           (t.v_active != 12'd0) && (t.v_active <= t.v_sync_start) &&
           (t.v_sync_start < t.v_sync_end) && (t.v_sync_end <= t.v_total);
  endfunction

  state_t      state_q, state_d;
  logic        live_q, live_d;    // counters hold valid raster positions
  logic [11:0] h_cnt_q, h_cnt_d;
  logic [11:0] v_cnt_q, v_cnt_d;
  timing_t     act_q, act_d;
  timing_t     stg_q, stg_d;
  logic        pend_q, pend_d;    // staging holds an accepted set that is not yet committed
  logic        err_q, err_d;
  logic [11:0] h_pos_q, h_pos_d;
  logic [11:0] v_pos_q, v_pos_d;
  logic        h_sync_q, h_sync_d;
  logic        v_sync_q, v_sync_d;
  logic        pix_en_q, pix_en_d;
  logic        fs_q, fs_d;

  timing_t upd;
  logic    upd_valid;
  logic    h_wrap, v_wrap;
  logic    commit_now;
  logic    restart;

  assign upd = {h_active_i, h_sync_start_i, h_sync_end_i, h_total_i,
                v_active_i, v_sync_start_i, v_sync_end_i, v_total_i};

  always_comb begin
    state_d   = state_q;
    live_d    = live_q;
    h_cnt_d   = h_cnt_q;
    v_cnt_d   = v_cnt_q;
    act_d     = act_q;
    stg_d     = stg_q;
    pend_d    = pend_q;
    err_d     = err_q;
    h_pos_d   = 12'd0;
    v_pos_d   = 12'd0;
    h_sync_d  = 1'b0;
    v_sync_d  = 1'b0;
    pix_en_d  = 1'b0;
    fs_d      = 1'b0;

    upd_valid = timing_ok(upd);
    h_wrap    = (h_cnt_q == act_q.h_total);
    v_wrap    = (v_cnt_q == act_q.v_total);

`ifdef VIDEO_TIMING_SHADOW_EN
    // A pending set waits for the last pixel of the frame. When the raster is
    // not live it commits at once, because no frame is in flight.
    commit_now = pend_q && (!live_q || (h_wrap && v_wrap));
    restart    = 1'b0;
`else
    // A pending set commits on the cycle after the accept and the raster restarts.
    commit_now = pend_q;
    restart    = pend_q;
`endif

    // The first cycle in RUN only arms the counters. (0,0) is decoded on the
    // following edge, so frame_start appears two edges after enable is sampled.
    state_d = enable_i ? ST_RUN : ST_IDLE;
    live_d  = enable_i && (state_q == ST_RUN);

    if (!enable_i || !live_q || restart) begin
      h_cnt_d = 12'd0;
      v_cnt_d = 12'd0;
    end else if (h_wrap) begin
      h_cnt_d = 12'd0;
      v_cnt_d = v_wrap ? 12'd0 : v_cnt_q + 12'd1;
    end else begin
      h_cnt_d = h_cnt_q + 12'd1;
    end

    // Every output is decoded from the same counter value using the same
    // active set, so all outputs stay aligned one clock behind the counters.
    if (enable_i && live_q) begin
      h_pos_d  = h_cnt_q;
      v_pos_d  = v_cnt_q;
      h_sync_d = (h_cnt_q >= act_q.h_sync_start) && (h_cnt_q < act_q.h_sync_end);
      v_sync_d = (v_cnt_q >= act_q.v_sync_start) && (v_cnt_q < act_q.v_sync_end);
      pix_en_d = (h_cnt_q < act_q.h_active) && (v_cnt_q < act_q.v_active);
      fs_d     = (h_cnt_q == 12'd0) && (v_cnt_q == 12'd0);
    end

    // A commit copies the staging content from before this edge, so an update
    // that arrives on the same edge waits for the next commit point.
    if (commit_now) begin
      act_d  = stg_q;
      pend_d = 1'b0;
    end

    if (timing_update_i) begin
      if (upd_valid) begin
        stg_d = upd;
        err_d = 1'b0;
        if (state_q == ST_IDLE) begin
          act_d  = upd;
          pend_d = 1'b0;
        end else begin
          pend_d = 1'b1;
        end
      end else begin
        err_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= ST_IDLE;
      live_q   <= 1'b0;
      h_cnt_q  <= 12'd0;
      v_cnt_q  <= 12'd0;
      act_q    <= TIMING_DEF;
      stg_q    <= TIMING_DEF;
      pend_q   <= 1'b0;
      err_q    <= 1'b0;
      h_pos_q  <= 12'd0;
      v_pos_q  <= 12'd0;
      h_sync_q <= 1'b0;
      v_sync_q <= 1'b0;
      pix_en_q <= 1'b0;
      fs_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      live_q   <= live_d;
      h_cnt_q  <= h_cnt_d;
      v_cnt_q  <= v_cnt_d;
      act_q    <= act_d;
      stg_q    <= stg_d;
      pend_q   <= pend_d;
      err_q    <= err_d;
      h_pos_q  <= h_pos_d;
      v_pos_q  <= v_pos_d;
      h_sync_q <= h_sync_d;
      v_sync_q <= v_sync_d;
      pix_en_q <= pix_en_d;
      fs_q     <= fs_d;
    end
  end

  assign h_pos_o        = h_pos_q;
  assign v_pos_o        = v_pos_q;
  assign h_sync_o       = h_sync_q;
  assign v_sync_o       = v_sync_q;
  assign pixel_en_o     = pix_en_q;
  assign frame_start_o  = fs_q;
  assign timing_error_o = err_q;
  assign dbg_state_o    = state_q;

endmodule

// File: tb/tb_video_timing_ctl.sv
// Testbench for video_timing_ctl. Expected output words are generated from the
// raster description (nested line/pixel loops) and pushed to a queue. They are
// popped one per clock and compared against the DUT outputs.
module tb_video_timing_ctl;

  typedef struct packed {
    logic [11:0] h_active;
    logic [11:0] h_sync_start;
    logic [11:0] h_sync_end;
    logic [11:0] h_total;
    logic [11:0] v_active;
    logic [11:0] v_sync_start;
    logic [11:0] v_sync_end;
    logic [11:0] v_total;
  } timing_t;

  localparam int W = 28;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic        enable = 1'b0;
  logic [11:0] h_active = '0, h_sync_start = '0, h_sync_end = '0, h_total = '0;
  logic [11:0] v_active = '0, v_sync_start = '0, v_sync_end = '0, v_total = '0;
  logic        timing_update = 1'b0;
  logic [11:0] h_pos, v_pos;
  logic        h_sync, v_sync, pixel_en, frame_start, timing_error, dbg_state;

  video_timing_ctl dut (
    .clk             (clk),
    .rst             (rst),
    .enable_i        (enable),
    .h_active_i      (h_active),
    .h_sync_start_i  (h_sync_start),
    .h_sync_end_i    (h_sync_end),
    .h_total_i       (h_total),
    .v_active_i      (v_active),
    .v_sync_start_i  (v_sync_start),
    .v_sync_end_i    (v_sync_end),
    .v_total_i       (v_total),
    .timing_update_i (timing_update),
    .h_pos_o         (h_pos),
    .v_pos_o         (v_pos),
    .h_sync_o        (h_sync),
    .v_sync_o        (v_sync),
    .pixel_en_o      (pixel_en),
    .frame_start_o   (frame_start),
    .timing_error_o  (timing_error),
    .dbg_state_o     (dbg_state)
  );

  logic [W-1:0] out_w;
  assign out_w = {h_pos, v_pos, h_sync, v_sync, pixel_en, frame_start};

  // ---------------- scoreboard ----------------
  logic [W-1:0] exp_q[$];
  int n_total = 0;
  int n_bad   = 0;

  task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Push the first 'count' pixels of a frame in raster order.
  task automatic push_pixels(input timing_t t, input int count);
    int n = 0;
    for (int v = 0; v <= int'(t.v_total); v++) begin
      for (int h = 0; h <= int'(t.h_total); h++) begin
        logic hs, vs, pe, fs;
        if (n >= count) return;
        hs = (h >= int'(t.h_sync_start)) && (h < int'(t.h_sync_end));
        vs = (v >= int'(t.v_sync_start)) && (v < int'(t.v_sync_end));
        pe = (h < int'(t.h_active)) && (v < int'(t.v_active));
        fs = (h == 0) && (v == 0);
        exp_q.push_back({12'(h), 12'(v), hs, vs, pe, fs});
        n++;
      end
    end
  endtask

  task automatic push_frames(input timing_t t, input int frames);
    int len = (int'(t.h_total) + 1) * (int'(t.v_total) + 1);
    repeat (frames) push_pixels(t, len);
  endtask

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic tick_chk();
    step();
    if (exp_q.size() == 0) begin
      n_total++;
      n_bad++;
      $display("FAIL sb_underflow got=%h exp=none", out_w);
    end else begin
      chk("pix", out_w, exp_q.pop_front());
    end
  endtask

  task automatic tick_n(input int n);
    repeat (n) tick_chk();
  endtask

  task automatic drain();
    while (exp_q.size() > 0) tick_chk();
  endtask

  // Pulse timing_update for one edge. in_stream selects whether that edge also
  // consumes a scoreboard entry.
  task automatic drive_update(input timing_t t, input bit in_stream);
    {h_active, h_sync_start, h_sync_end, h_total,
     v_active, v_sync_start, v_sync_end, v_total} = t;
    timing_update = 1'b1;
    if (in_stream) tick_chk();
    else step();
    timing_update = 1'b0;
  endtask

  // Enable is sampled on the first edge. The outputs stay idle for that edge and
  // the next, and (0,0) follows on the edge after.
  task automatic start_run();
    enable = 1'b1;
    step();
    chk("arm0", out_w, '0);
    step();
    chk("arm1", out_w, '0);
  endtask

  // ---------------- stimulus ----------------
  timing_t cfg_def, cfg_small, cfg_bad, cfg_big, cfg_a, cfg_b;

  initial begin
    cfg_def   = {12'd720, 12'd732, 12'd796, 12'd863, 12'd576, 12'd581, 12'd586, 12'd624};
    cfg_small = {12'd4, 12'd5, 12'd7, 12'd7,  12'd2, 12'd3, 12'd5, 12'd5};
    cfg_bad   = {12'd4, 12'd3, 12'd7, 12'd7,  12'd2, 12'd3, 12'd5, 12'd5};
    cfg_big   = {12'd4, 12'd5, 12'd7, 12'd9,  12'd2, 12'd3, 12'd5, 12'd5};
    cfg_a     = {12'd4, 12'd5, 12'd7, 12'd11, 12'd2, 12'd3, 12'd5, 12'd5};
    cfg_b     = {12'd6, 12'd7, 12'd9, 12'd10, 12'd3, 12'd4, 12'd5, 12'd6};

    // Reset. Updates driven during reset must have no effect.
    step();
    drive_update(cfg_small, 1'b0);
    drive_update(cfg_bad, 1'b0);
    rst = 1'b1;
    step();
    chk("rst_out", out_w, '0);
    chk("rst_err", W'(timing_error), W'(0));
    chk("rst_state", W'(dbg_state), W'(0));

    // Default raster: the first two lines.
    start_run();
    push_pixels(cfg_def, 2 * 864);
    drain();
    enable = 1'b0;
    step();
    chk("stop_def", out_w, '0);

    // Load the small raster while idle.
    drive_update(cfg_small, 1'b0);
    chk("idle_upd_err", W'(timing_error), W'(0));

    // Two full frames, then an abort at (3,1) and a restart.
    start_run();
    push_frames(cfg_small, 2);
    drain();
    push_pixels(cfg_small, 12);
    drain();
    enable = 1'b0;
    step();
    chk("abort", out_w, '0);
    start_run();

    // A rejected update sets the error flag and leaves the raster unchanged.
    push_frames(cfg_small, 1);
    tick_n(10);
    drive_update(cfg_bad, 1'b1);
    chk("bad_err", W'(timing_error), W'(1));
    drain();
    push_frames(cfg_small, 1);
    drain();
    chk("bad_err_sticky", W'(timing_error), W'(1));

`ifdef VIDEO_TIMING_SHADOW_EN
    // A mid-frame update finishes the current frame, then the new timing starts.
    push_frames(cfg_small, 1);
    tick_n(13);
    drive_update(cfg_big, 1'b1);
    chk("good_err", W'(timing_error), W'(0));
    drain();
    push_frames(cfg_big, 1);
    drain();

    // Back-to-back updates in one frame: only the last one is applied.
    push_frames(cfg_big, 1);
    tick_n(5);
    drive_update(cfg_a, 1'b1);
    tick_n(3);
    drive_update(cfg_b, 1'b1);
    drain();
    push_frames(cfg_b, 1);
    drain();

    // An update on the frame-end edge: the next frame uses the older staged
    // set, and the frame after that uses the new one.
    push_frames(cfg_b, 1);
    tick_n(20);
    drive_update(cfg_a, 1'b1);
    while (exp_q.size() > 1) tick_chk();
    drive_update(cfg_small, 1'b1);
    push_frames(cfg_a, 1);
    push_frames(cfg_small, 1);
    drain();
`else
    // Each update truncates the frame. The cycle after the accept edge still
    // shows old timing, and then (0,0) appears with the new timing.
    push_frames(cfg_small, 1);
    tick_n(13);
    drive_update(cfg_big, 1'b1);
    chk("good_err", W'(timing_error), W'(0));
    tick_chk();
    exp_q.delete();
    push_frames(cfg_big, 2);
    drain();

    // Two updates two cycles apart: each one restarts the raster.
    push_frames(cfg_big, 1);
    tick_n(5);
    drive_update(cfg_a, 1'b1);
    tick_chk();
    exp_q.delete();
    push_frames(cfg_a, 1);
    drive_update(cfg_b, 1'b1);
    tick_chk();
    exp_q.delete();
    push_frames(cfg_b, 2);
    drain();
`endif

    enable = 1'b0;
    step();
    chk("stop_end", out_w, '0);
    chk("end_state", W'(dbg_state), W'(0));

    // ---------------- report ----------------
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
